// File: rtl/combo_pkg.sv
// Shared constants for the combo lock entry front end: state codes, digit width,
// the lockout override code and a code-width helper.
package combo_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [15:0] OVERRIDE_CODE = 16'hFFFF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    function automatic int unsigned code_width(input int unsigned digits);
        return DIGIT_W * digits;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter; expire_c flags the enabled cycle whose tick empties it.
// Used for both the lockout period and the core response timeout.
module lockout_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(CYCLES);
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire_c = en && (count == CNT_W'(1));

endmodule

// File: rtl/combo_entry_sequencer.sv
// Keypad entry sequencer for the combo lock core: assembles hex digits, strobes the
// core, tracks failures and enforces a timed lockout. Macro: LOCKOUT_OVERRIDE_EN.
module combo_entry_sequencer
    import combo_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned RESP_TIMEOUT   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               digit_valid,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               clear,
    input  logic                               enter,
    output logic [DIGIT_W*DIGITS-1:0]          code_out,
    output logic                               press_out,
    input  logic                               core_done,
    input  logic                               core_match,
    output logic                               busy,
    output logic                               locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
    output logic [$clog2(DIGITS+1)-1:0]        digit_cnt
);

    localparam int unsigned CODE_W = code_width(DIGITS);
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    logic [2:0]        state, state_n;
    logic [CODE_W-1:0] code_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [FAIL_W-1:0] fail_n;
    logic              fail_attempt;
    logic              lock_expire_c;
    logic              resp_expire_c;

`ifdef LOCKOUT_OVERRIDE_EN
    logic [CODE_W-1:0] shadow, shadow_n;
    logic [CNT_W-1:0]  shadow_cnt, shadow_cnt_n;
`endif

    lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lock_timer (
        .clk      (clk),
        .reset    (reset),
        .load     ((state_n == ST_LOCKOUT) && (state != ST_LOCKOUT)),
        .en       (state == ST_LOCKOUT),
        .expire_c (lock_expire_c)
    );

    lockout_timer #(.CYCLES(RESP_TIMEOUT)) u_resp_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_ISSUE),
        .en       (state == ST_WAIT),
        .expire_c (resp_expire_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next data; a digit is absorbed before enter is judged.
    always_comb begin
        state_n      = state;
        code_n       = code_out;
        cnt_n        = digit_cnt;
        fail_n       = fail_cnt;
        fail_attempt = 1'b0;
`ifdef LOCKOUT_OVERRIDE_EN
        shadow_n     = '0;
        shadow_cnt_n = '0;
`endif
        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (clear) begin
                    code_n  = '0;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    if (digit_valid && (digit_cnt < CNT_W'(DIGITS))) begin
                        code_n  = {code_out[CODE_W-DIGIT_W-1:0], digit};
                        cnt_n   = digit_cnt + CNT_W'(1);
                        state_n = ST_COLLECT;
                    end
                    if (enter && (cnt_n != '0)) begin
                        if (cnt_n == CNT_W'(DIGITS)) begin
                            state_n = ST_ISSUE;
                        end else begin
                            fail_attempt = 1'b1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done && core_match) begin
                    fail_n  = '0;
                    code_n  = '0;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (core_done || resp_expire_c) begin
                    fail_attempt = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (lock_expire_c) begin
                    fail_n  = '0;
                    state_n = ST_IDLE;
                end
`ifdef LOCKOUT_OVERRIDE_EN
                shadow_n     = shadow;
                shadow_cnt_n = shadow_cnt;
                if (digit_valid && (shadow_cnt < CNT_W'(DIGITS))) begin
                    shadow_n     = {shadow[CODE_W-DIGIT_W-1:0], digit};
                    shadow_cnt_n = shadow_cnt + CNT_W'(1);
                end
                if (enter) begin
                    if ((shadow_cnt_n == CNT_W'(DIGITS)) && (shadow_n == CODE_W'(OVERRIDE_CODE))) begin
                        fail_n  = '0;
                        state_n = ST_IDLE;
                    end
                    shadow_n     = '0;
                    shadow_cnt_n = '0;
                end
`endif
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (fail_attempt) begin
            code_n  = '0;
            cnt_n   = '0;
            fail_n  = (fail_cnt < FAIL_W'(MAX_FAILS)) ? fail_cnt + FAIL_W'(1) : fail_cnt;
            state_n = (fail_n == FAIL_W'(MAX_FAILS)) ? ST_LOCKOUT : ST_IDLE;
        end
    end

    // Outputs are registered from the next-state decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_out   <= '0;
            digit_cnt  <= '0;
            fail_cnt   <= '0;
            press_out  <= 1'b0;
            busy       <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            code_out   <= code_n;
            digit_cnt  <= cnt_n;
            fail_cnt   <= fail_n;
            press_out  <= (state_n == ST_ISSUE);
            busy       <= (state_n == ST_ISSUE) || (state_n == ST_WAIT) || (state_n == ST_LOCKOUT);
            locked_out <= (state_n == ST_LOCKOUT);
        end
    end

`ifdef LOCKOUT_OVERRIDE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            shadow_cnt <= '0;
        end else begin
            shadow     <= shadow_n;
            shadow_cnt <= shadow_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_combo_entry_sequencer.sv
// Bench for combo_entry_sequencer: directed scenarios plus randomized attempts
// checked against a transaction-level model of entry, verdict and lockout.
module tb_combo_entry_sequencer;

    localparam int unsigned DIGITS         = 4;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 1024;
    localparam int unsigned RESP_TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        clear;
    logic        enter;
    logic [15:0] code_out;
    logic        press_out;
    logic        core_done;
    logic        core_match;
    logic        busy;
    logic        locked_out;
    logic [1:0]  fail_cnt;
    logic [2:0]  digit_cnt;

    int checks   = 0;
    int failures = 0;
    int m_fail   = 0;

    combo_entry_sequencer #(
        .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .clear(clear), .enter(enter), .code_out(code_out), .press_out(press_out),
        .core_done(core_done), .core_match(core_match), .busy(busy),
        .locked_out(locked_out), .fail_cnt(fail_cnt), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic push_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
        push_enter();
    endtask

    function automatic int sat_inc(input int f);
        return (f < int'(MAX_FAILS)) ? f + 1 : f;
    endfunction

    // Waits out a lockout; returns the number of sampled cycles locked_out was high.
    task automatic wait_unlock(output int n);
        n = (locked_out === 1'b1) ? 1 : 0;
        while (locked_out === 1'b1 && n <= int'(LOCKOUT_CYCLES) + 4) begin
            tick();
            if (locked_out === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({code_out, press_out, busy, locked_out, fail_cnt, digit_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_values: got code=%h press=%b busy=%b lock=%b fail=%0d cnt=%0d expected all 0",
                     code_out, press_out, busy, locked_out, fail_cnt, digit_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_accept();
        for (int i = 0; i < 4; i++) key(4'hA);
        checks++;
        if (code_out !== 16'hAAAA || digit_cnt !== 3'd4) begin
            failures++;
            $display("FAIL accept_code: got code=%h cnt=%0d expected AAAA cnt=4", code_out, digit_cnt);
        end
        push_enter();
        checks++;
        if (press_out !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL accept_press: got press=%b busy=%b expected 1 1", press_out, busy);
        end
        tick();
        checks++;
        if (press_out !== 1'b0 || busy !== 1'b1 || code_out !== 16'hAAAA) begin
            failures++;
            $display("FAIL accept_wait: got press=%b busy=%b code=%h expected 0 1 AAAA", press_out, busy, code_out);
        end
        repeat (5) tick();
        core_done = 1'b1; core_match = 1'b1;
        tick();
        core_done = 1'b0; core_match = 1'b0;
        m_fail = 0;
        checks++;
        if (busy !== 1'b0 || fail_cnt !== 2'(m_fail) || code_out !== 16'h0 || digit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL accept_done: got busy=%b fail=%0d code=%h cnt=%0d expected 0 %0d 0 0",
                     busy, fail_cnt, code_out, digit_cnt, m_fail);
        end
    endtask

    task automatic mismatch_attempt(input logic [15:0] c);
        enter_code(c);
        tick();
        core_done = 1'b1; core_match = 1'b0;
        tick();
        core_done = 1'b0;
        m_fail = sat_inc(m_fail);
    endtask

    task automatic test_mismatch();
        mismatch_attempt(16'h1000);
        checks++;
        if (fail_cnt !== 2'(m_fail) || busy !== 1'b0 || code_out !== 16'h0 || locked_out !== 1'b0) begin
            failures++;
            $display("FAIL mismatch: got fail=%0d busy=%b code=%h lock=%b expected %0d 0 0 0",
                     fail_cnt, busy, code_out, locked_out, m_fail);
        end
    endtask

    task automatic test_lockout();
        int n;
        bit bad;
        mismatch_attempt(16'($urandom));
        mismatch_attempt(16'($urandom));
        checks++;
        if (locked_out !== 1'b1 || busy !== 1'b1 || fail_cnt !== 2'(MAX_FAILS)) begin
            failures++;
            $display("FAIL lockout_entry: got lock=%b busy=%b fail=%0d expected 1 1 %0d",
                     locked_out, busy, fail_cnt, MAX_FAILS);
        end
        n = 1; bad = 1'b0;
        while (locked_out === 1'b1 && n <= int'(LOCKOUT_CYCLES) + 4) begin
            digit_valid = 1'($urandom_range(0, 1));
            digit       = 4'($urandom_range(0, 15));
            tick();
            if (code_out !== 16'h0 || digit_cnt !== 3'd0) bad = 1'b1;
            if (locked_out === 1'b1) n++;
        end
        digit_valid = 1'b0;
        m_fail = 0;
        checks++;
        if (n != int'(LOCKOUT_CYCLES)) begin
            failures++;
            $display("FAIL lockout_length: got %0d cycles expected %0d", n, LOCKOUT_CYCLES);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL lockout_keys: got code/digit_cnt change during lockout expected none");
        end
        checks++;
        if (fail_cnt !== 2'(m_fail) || busy !== 1'b0) begin
            failures++;
            $display("FAIL lockout_exit: got fail=%0d busy=%b expected 0 0", fail_cnt, busy);
        end
    endtask

    task automatic test_timeout();
        enter_code(16'hBBCD);
        checks++;
        if (press_out !== 1'b1 || code_out !== 16'hBBCD) begin
            failures++;
            $display("FAIL timeout_press: got press=%b code=%h expected 1 BBCD", press_out, code_out);
        end
        tick();
        repeat (RESP_TIMEOUT - 1) tick();
        checks++;
        if (busy !== 1'b1 || fail_cnt !== 2'(m_fail)) begin
            failures++;
            $display("FAIL timeout_early: got busy=%b fail=%0d expected 1 %0d", busy, fail_cnt, m_fail);
        end
        tick();
        m_fail = sat_inc(m_fail);
        checks++;
        if (busy !== 1'b0 || fail_cnt !== 2'(m_fail) || code_out !== 16'h0) begin
            failures++;
            $display("FAIL timeout_fail: got busy=%b fail=%0d code=%h expected 0 %0d 0", busy, fail_cnt, code_out, m_fail);
        end
        core_done = 1'b1; core_match = 1'b1;
        tick();
        core_done = 1'b0; core_match = 1'b0;
        tick();
        checks++;
        if (fail_cnt !== 2'(m_fail) || busy !== 1'b0) begin
            failures++;
            $display("FAIL late_done: got fail=%0d busy=%b expected %0d 0", fail_cnt, busy, m_fail);
        end
    endtask

    task automatic test_clear();
        key(4'h9);
        key(4'h8);
        checks++;
        if (code_out !== 16'h0098 || digit_cnt !== 3'd2) begin
            failures++;
            $display("FAIL clear_pre: got code=%h cnt=%0d expected 0098 2", code_out, digit_cnt);
        end
        clear = 1'b1; digit_valid = 1'b1; digit = 4'h7;
        tick();
        clear = 1'b0; digit_valid = 1'b0;
        push_enter();
        checks++;
        if (digit_cnt !== 3'd0 || code_out !== 16'h0 || press_out !== 1'b0 || fail_cnt !== 2'(m_fail) || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_enter: got cnt=%0d code=%h press=%b fail=%0d busy=%b expected 0 0 0 %0d 0",
                     digit_cnt, code_out, press_out, fail_cnt, m_fail, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_press;
        key(4'h3);
        key(4'h7);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({code_out, press_out, busy, locked_out, fail_cnt, digit_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_async: got code=%h press=%b busy=%b lock=%b fail=%0d cnt=%0d expected all 0",
                     code_out, press_out, busy, locked_out, fail_cnt, digit_cnt);
        end
        saw_press = 1'b0;
        enter = 1'b1;
        repeat (3) begin tick(); if (press_out !== 1'b0) saw_press = 1'b1; end
        enter = 1'b0;
        reset = 1'b0;
        repeat (3) begin tick(); if (press_out !== 1'b0) saw_press = 1'b1; end
        m_fail = 0;
        checks++;
        if (saw_press || code_out !== 16'h0 || fail_cnt !== 2'(m_fail)) begin
            failures++;
            $display("FAIL reset_after: got press_seen=%b code=%h fail=%0d expected 0 0 0", saw_press, code_out, fail_cnt);
        end
    endtask

    task automatic test_override();
        int n;
        for (int i = 0; i < int'(MAX_FAILS); i++) begin
            key(4'($urandom_range(0, 15)));
            push_enter();
            m_fail = sat_inc(m_fail);
        end
        checks++;
        if (locked_out !== 1'b1 || fail_cnt !== 2'(m_fail)) begin
            failures++;
            $display("FAIL short_lockout: got lock=%b fail=%0d expected 1 %0d", locked_out, fail_cnt, m_fail);
        end
        enter_code(16'h1234);
        checks++;
        if (locked_out !== 1'b1 || press_out !== 1'b0) begin
            failures++;
            $display("FAIL override_wrong: got lock=%b press=%b expected 1 0", locked_out, press_out);
        end
        enter_code(16'hFFFF);
`ifdef LOCKOUT_OVERRIDE_EN
        m_fail = 0;
        checks++;
        if (locked_out !== 1'b0 || press_out !== 1'b0 || fail_cnt !== 2'(m_fail) || busy !== 1'b0) begin
            failures++;
            $display("FAIL override_ok: got lock=%b press=%b fail=%0d busy=%b expected 0 0 0 0",
                     locked_out, press_out, fail_cnt, busy);
        end
`else
        checks++;
        if (locked_out !== 1'b1 || press_out !== 1'b0) begin
            failures++;
            $display("FAIL override_absent: got lock=%b press=%b expected 1 0", locked_out, press_out);
        end
        wait_unlock(n);
        m_fail = 0;
`endif
        tick();
    endtask

    // Random attempts: 1..5 digits, then a matching, mismatching or silent core.
    task automatic test_random();
        int n, v, dly, lk;
        int exp_code;
        logic [3:0] d;
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 5);
            exp_code = 0;
            for (int i = 0; i < n; i++) begin
                d = 4'($urandom_range(0, 15));
                if (i < int'(DIGITS)) exp_code = (exp_code * 16 + int'(d)) % 65536;
                key(d);
            end
            checks++;
            if (digit_cnt !== 3'((n < int'(DIGITS)) ? n : int'(DIGITS)) || code_out !== 16'(exp_code)) begin
                failures++;
                $display("FAIL rnd_collect[%0d]: got cnt=%0d code=%h expected %0d %h", it, digit_cnt, code_out,
                         (n < int'(DIGITS)) ? n : int'(DIGITS), 16'(exp_code));
            end
            push_enter();
            if (n >= int'(DIGITS)) begin
                checks++;
                if (press_out !== 1'b1 || code_out !== 16'(exp_code)) begin
                    failures++;
                    $display("FAIL rnd_press[%0d]: got press=%b code=%h expected 1 %h", it, press_out, code_out, 16'(exp_code));
                end
                tick();
                v = $urandom_range(0, 2);
                if (v < 2) begin
                    dly = $urandom_range(0, 10);
                    repeat (dly) tick();
                    core_done = 1'b1; core_match = (v == 0);
                    tick();
                    core_done = 1'b0; core_match = 1'b0;
                end else begin
                    repeat (RESP_TIMEOUT) tick();
                end
                m_fail = (v == 0) ? 0 : sat_inc(m_fail);
            end else begin
                checks++;
                if (press_out !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_nopress[%0d]: got press=%b expected 0", it, press_out);
                end
                m_fail = sat_inc(m_fail);
            end
            checks++;
            if (fail_cnt !== 2'(m_fail) || code_out !== 16'h0 || digit_cnt !== 3'd0
                || locked_out !== (m_fail == int'(MAX_FAILS))) begin
                failures++;
                $display("FAIL rnd_verdict[%0d]: got fail=%0d code=%h cnt=%0d lock=%b expected %0d 0 0 %b",
                         it, fail_cnt, code_out, digit_cnt, locked_out, m_fail, m_fail == int'(MAX_FAILS));
            end
            if (m_fail == int'(MAX_FAILS)) begin
                wait_unlock(lk);
                m_fail = 0;
                checks++;
                if (lk != int'(LOCKOUT_CYCLES) || fail_cnt !== 2'(m_fail)) begin
                    failures++;
                    $display("FAIL rnd_lockout[%0d]: got cycles=%0d fail=%0d expected %0d 0", it, lk, fail_cnt, LOCKOUT_CYCLES);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; digit_valid = 1'b0; digit = 4'h0; clear = 1'b0;
        enter = 1'b0; core_done = 1'b0; core_match = 1'b0;
        test_reset();
        test_accept();
        test_mismatch();
        test_lockout();
        test_timeout();
        test_clear();
        test_reset_mid();
        test_override();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
